// File: rtl/add_restore_16bit.sv
// ----------------------------------------------------------------------------
// add_restore_16bit
//
// Rebuilds the raw detector sample from the error path by adding the noise
// estimate back onto the error sample: out1 = clamp(in1 + in2). The result
// feeds the capture/monitor path, so every clipped sample is flagged and
// counted.
//
// Two-stage pipeline:
//   stage 1 : exact WIDTH+1 bit sum of the two signed inputs
//   stage 2 : saturation to WIDTH bits, clip flag, output register
// Both stages advance together whenever the output slot is free or being
// drained, so throughput is one sample per clock and latency is two clocks.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input sample pair valid
//   in_ready   pipeline can take a pair this cycle
//   in1        signed error sample
//   in2        signed noise estimate
//   out_valid  out1 / sat_flag valid
//   out_ready  downstream accepts this cycle
//   out1       signed saturated sum
//   sat_flag   out1 was clipped
//   sat_count  number of clipped samples delivered, sticks at all-ones
//   clr_count  synchronous clear of sat_count
// ----------------------------------------------------------------------------
module add_restore_16bit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic             sat_flag,
    output logic [CNT_W-1:0] sat_count,
    input  logic             clr_count
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_s1_valid;
    logic [WIDTH:0]   r_s1_sum;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out1;
    logic             r_sat_flag;
    logic [CNT_W-1:0] r_sat_count;

    logic             w_adv;
    logic             w_in_xfer;
    logic [WIDTH:0]   w_sum_next;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sat_val;
    logic             w_out_xfer;
    logic             w_cnt_inc;

    // The whole pipeline moves as one; a stalled output freezes both stages.
    assign w_adv      = out_ready | ~r_out_valid;
    assign w_in_xfer  = in_valid & w_adv;

    // Sign-extend by one bit so the sum can never wrap.
    assign w_sum_next = {in1[WIDTH-1], in1} + {in2[WIDTH-1], in2};

    // The sum fits in WIDTH bits exactly when its top two bits agree; the top
    // bit then tells which rail to clamp to.
    assign w_ovf      = r_s1_sum[WIDTH] ^ r_s1_sum[WIDTH-1];
    assign w_sat_val  = w_ovf ? (r_s1_sum[WIDTH] ? SAT_MIN : SAT_MAX)
                              : r_s1_sum[WIDTH-1:0];

    assign w_out_xfer = r_out_valid & out_ready;
    assign w_cnt_inc  = w_out_xfer & r_sat_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (w_in_xfer) begin
                r_s1_sum <= w_sum_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out1      <= '0;
            r_sat_flag  <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out1     <= w_sat_val;
                r_sat_flag <= w_ovf;
            end
        end
    end

    // A clear that coincides with a clipped delivery keeps that event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (clr_count) begin
            r_sat_count <= w_cnt_inc ? CNT_ONE : '0;
        end else if (w_cnt_inc && (r_sat_count != CNT_MAX)) begin
            r_sat_count <= r_sat_count + CNT_ONE;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out1      = r_out1;
    assign sat_flag  = r_sat_flag;
    assign sat_count = r_sat_count;

endmodule

// File: doc/add_restore_16bit.md
Name: add_restore_16bit

Overview:
- Sequential saturating adder that reverses the error-path subtraction: reconstructs out1 = in1 + in2 (error sample plus noise estimate) to recover the raw detector sample for monitoring and calibration.
- 2-stage pipeline with valid/ready handshake on both sides, per-sample saturation flag and a saturating overflow event counter.
- Sits on the sample stream after the error subtractor, feeding the capture/monitor path.

Parameters:
- WIDTH, 16, sample width (signed two's complement) of in1, in2 and out1.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample pair valid.
- in_ready  out  1  block can accept the input this cycle.
- in1  in  WIDTH  signed error sample.
- in2  in  WIDTH  signed noise estimate.
- out_valid  out  1  out1/sat_flag valid.
- out_ready  in  1  downstream accepts this cycle.
- out1  out  WIDTH  signed saturated sum.
- sat_flag  out  1  out1 was clipped; aligned with out1.
- sat_count  out  CNT_W  count of saturated samples delivered; sticks at max.
- clr_count  in  1  synchronous clear of sat_count.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset, on rising edge with rst=1: s1_valid=0, out_valid=0, out1=0, sat_flag=0, sat_count=0. In-flight samples are discarded. Reset overrides all other inputs, including clr_count.
- Advance: adv = out_ready | ~out_valid. in_ready = adv (combinational from out_ready and out_valid only, never from in_valid).
- Input transfer: in_valid & in_ready.
- Stage 1, when adv=1:
  - s1_valid <= in_valid.
  - s1_sum <= sext17(in1) + sext17(in2), i.e. a WIDTH+1-bit exact sum.
  - s1_sum is loaded only on a transfer; otherwise it holds.
- Stage 2, when adv=1:
  - out_valid <= s1_valid.
  - If s1_valid: out1 <= sat(s1_sum) and sat_flag <= clipped.
  - If s1_valid=0: out1 and sat_flag hold.
- Stall: when adv=0, all stages hold. out1, sat_flag and out_valid must stay stable while out_valid=1 and out_ready=0.
- Saturation, WIDTH=16:
  - sum > 32767 -> 32767, clipped=1.
  - sum < -32768 -> -32768, clipped=1.
  - Otherwise out1 = sum[15:0], clipped=0.
  - The exact boundary values 32767 and -32768 are not clipped.
- Latency: 2 cycles from input transfer to out_valid=1 when out_ready is held high. Throughput is 1 sample/cycle.
- Bubbles: an empty slot (s1_valid=0) is a bubble. It occupies a stage like a sample; bubbles are removed only while out_valid=0.
- sat_count:
  - Increments by 1 on an output transfer (out_valid & out_ready) with sat_flag=1.
  - Holds at 2^CNT_W-1 with no wrap.
  - clr_count=1 with no increment -> 0.
  - clr_count=1 together with an increment -> 1 (the event is not lost).

Test Plan:
- Reset: assert rst for 2 cycles mid-stream with 2 samples in flight -> next cycle out_valid=0, out1=0, sat_flag=0, sat_count=0; the dropped samples never appear at the output.
- Basic latency: out_ready=1, in1=1000, in2=-250, transfer at cycle T -> out_valid=1 at T+2 with out1=750, sat_flag=0; a back-to-back stream of 8 pairs produces 8 consecutive outputs in order.
- Saturation boundaries:
  - 30000+2767 -> 32767, flag 0.
  - 30000+2768 -> 32767, flag 1.
  - -32768+0 -> -32768, flag 0.
  - -20000+-20000 -> -32768, flag 1.
  - sat_count=2 after all four are delivered.
- Backpressure: stream 5 samples, drop out_ready for 3 cycles while out_valid=1 -> out1 is held stable, in_ready=0 during the stall, no sample is lost or duplicated, order is preserved.
- Counter edges:
  - Force 65535 saturated deliveries -> count=65535; one more -> stays 65535.
  - clr_count in the same cycle as a saturated delivery -> sat_count=1.
  - clr_count alone -> 0.
- Random: 10k random in1/in2 with random in_valid/out_ready -> outputs match a reference model computing clamp(in1+in2) and the flag; count matches the number of clipped outputs.
